// File: rtl/gray_code_unit.sv
// gray_code_unit: registered up/down Gray counter with load and wrap flag,
// plus an independent two-stage binary<->Gray converter pipeline.
module gray_code_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt_bin,
    output logic [WIDTH-1:0] cnt_gray,
    output logic             wrap,
    input  logic             conv_valid,
    input  logic             conv_mode,
    input  logic [WIDTH-1:0] conv_in,
    output logic             conv_out_valid,
    output logic [WIDTH-1:0] conv_out
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;

    logic             s1_valid;
    logic             s1_mode;
    logic [WIDTH-1:0] s1_data;

    logic [WIDTH-1:0] b2g;
    logic [WIDTH-1:0] g2b;
    logic [WIDTH-1:0] conv_nxt;

    // Counter next state: load beats step; Gray code follows the next binary value
    always_comb begin
        bin_nxt  = cnt_bin;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_val;
        end else if (en) begin
            if (up) begin
                bin_nxt  = cnt_bin + CNT_ONE;
                wrap_nxt = (cnt_bin == CNT_MAX);
            end else begin
                bin_nxt  = cnt_bin - CNT_ONE;
                wrap_nxt = (cnt_bin == CNT_ZERO);
            end
        end
        gray_nxt = bin_nxt ^ (bin_nxt >> 1);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_bin  <= '0;
            cnt_gray <= '0;
            wrap     <= 1'b0;
        end else begin
            cnt_bin  <= bin_nxt;
            cnt_gray <= gray_nxt;
            wrap     <= wrap_nxt;
        end
    end

    // Stage 1: capture the converter request every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= conv_valid;
            s1_mode  <= conv_mode;
            s1_data  <= conv_in;
        end
    end

    // Conversion functions on stage-1 data; binary bit i is the XOR of Gray bits i and above
    always_comb begin
        b2g = s1_data ^ (s1_data >> 1);
        g2b = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            g2b[i] = ^(s1_data >> i);
        end
        conv_nxt = s1_mode ? g2b : b2g;
    end

    // Stage 2: result register holds when no valid request is in stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_out_valid <= 1'b0;
            conv_out       <= '0;
        end else begin
            conv_out_valid <= s1_valid;
            if (s1_valid) begin
                conv_out <= conv_nxt;
            end
        end
    end

endmodule

// File: doc/gray_code_unit.md
# gray_code_unit

Parametrised, registered Gray-code unit: the sequential successor to the team's 4-bit combinational binary-to-Gray converter. Contains a WIDTH-bit up/down Gray counter with load, enable and wrap flag, plus an independent two-stage pipelined converter channel that performs binary-to-Gray or Gray-to-binary per transaction. It is used for pointer generation and code translation in clock-domain-crossing and encoder datapaths, on a single clock.

## Interface
Parameters:
- WIDTH, 4, code width in bits for counter and converter; legal range 2..32

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- en  input  1  counter step enable
- up  input  1  count direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  binary load value
- cnt_bin  output  WIDTH  registered binary count
- cnt_gray  output  WIDTH  registered Gray count, equal to cnt_bin ^ (cnt_bin >> 1)
- wrap  output  1  one-cycle pulse marking a counter wrap
- conv_valid  input  1  converter input valid
- conv_mode  input  1  0 = binary→Gray, 1 = Gray→binary
- conv_in  input  WIDTH  value to convert
- conv_out_valid  output  1  converter result valid
- conv_out  output  WIDTH  converter result

## Operation
- One clock domain; every output comes from a register; reset is synchronous and active-high.
- Reset values: cnt_bin = 0, cnt_gray = 0, wrap = 0, conv_out_valid = 0, conv_out = 0, all pipeline registers = 0.
- Counter priority per edge is rst > load > en.
  - load: cnt_bin ← load_val; cnt_gray ← gray(load_val); wrap ← 0.
  - en with up = 1: cnt_bin ← cnt_bin + 1, modulo 2^WIDTH.
  - en with up = 0: cnt_bin ← cnt_bin − 1, modulo 2^WIDTH.
  - No load and no en: hold all counter state; wrap ← 0.
- cnt_gray is updated in the same edge as cnt_bin.
  - It is derived from the next binary value, not from the current cnt_gray.
  - While counting, successive cnt_gray values differ in exactly one bit.
- wrap ← 1 for one cycle when:
  - an up step moves the count from 2^WIDTH−1 to 0, or
  - a down step moves the count from 0 to 2^WIDTH−1.
- In every other case wrap ← 0. A load never asserts wrap, including a load of 0 or of the maximum value.
- Converter functions:
  - Binary→Gray: g = b ^ (b >> 1).
  - Gray→binary: b[WIDTH−1] = g[WIDTH−1]; b[i] = b[i+1] ^ g[i] for i = WIDTH−2 down to 0. The chain is evaluated combinationally between stage 1 and stage 2.
- Converter pipeline:
  - Stage 1 registers conv_in, conv_mode and conv_valid unconditionally every cycle.
  - Stage 2 computes the selected function on the stage-1 data and registers conv_out and conv_out_valid.
  - conv_out updates only when stage-1 valid = 1 and holds otherwise.
  - conv_out_valid follows stage-1 valid every cycle.
- No backpressure. A new conversion may be accepted every cycle, and results emerge in input order.
- The converter and the counter are fully independent; simultaneous activity has no interaction.

## Timing
- Counter: load or en sampled at edge N; cnt_bin, cnt_gray and wrap are valid after edge N, a latency of 1 cycle.
- Converter: conv_valid sampled at edge N; conv_out_valid and conv_out are valid after edge N+1, a latency of 2 cycles, at a throughput of 1 per cycle.
- Reset mid-operation:
  - rst at edge N clears the counter, wrap and both pipeline stages after edge N.
  - Conversions in flight are discarded; conv_out_valid is 0 after edge N and after edge N+1, even if conv_valid was high at edges N−1 and N.
  - Inputs sampled at edge N while rst = 1 are ignored.
- load and en together: load wins, and no step occurs in that cycle.
- en held high continuously gives one step per cycle, and wrap can pulse every 2^WIDTH cycles.

## Test plan
- Reset, WIDTH=4: assert rst with en=1, load=1, conv_valid=1 → after release, cnt_bin=0, cnt_gray=0000, wrap=0, conv_out_valid=0.
- Up count full cycle, WIDTH=4: en=1, up=1 for 17 cycles → cnt_gray sequence 0000, 0001, 0011, 0010, …, 1000, then 0000; checks:
  - exactly one bit changes per step;
  - wrap=1 only in the cycle cnt_bin returns to 0.
- Load and down wrap:
  - load_val=5 → cnt_bin=5, cnt_gray=0111, wrap=0.
  - load_val=0, then en=1, up=0 → cnt_bin=15, cnt_gray=1000, wrap=1 for one cycle.
  - load=1 with en=1 and load_val=9 → cnt_bin=9, not 10.
- Converter back-to-back, WIDTH=4: conv_valid=1 on consecutive cycles with (mode 0, 8), (mode 1, 1100), (mode 0, 15), (mode 1, 1000) → two cycles later, conv_out = 1100, 1000 (8), 1000, 1111 (15) on consecutive cycles, with conv_out_valid high for exactly 4 cycles.
- Reset during conversion: conv_valid=1 at edges N−1 and N, rst=1 at edge N → conv_out_valid stays 0; conv_out=0.
- WIDTH=8 exhaustive: all 256 values through both modes → each binary→Gray result, fed back through Gray→binary, returns the original value; counter wraps from 255 to 0 with wrap=1.
